// File: rtl/scope_trace_rd_pkg.sv
// Shared constants and types for the scope trace reader.
// Holds the raster defaults, the colour codes, the capture RAM geometry,
// the reader FSM state type and the sample-to-row scaling helper.
package scope_trace_rd_pkg;

  localparam int unsigned H_ACT_DEF   = 640;
  localparam int unsigned V_ACT_DEF   = 480;
  localparam logic [5:0]  C_TRACE_DEF = 6'b111100;
  localparam logic [5:0]  C_GRID_DEF  = 6'b000101;

  localparam int unsigned RAM_DEPTH = 1024;
  localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH);
  localparam int unsigned RAM_DW    = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_DRAW,
    S_VBLANK
  } state_e;

  // Screen row of an 8-bit sample code; code 0 sits on y_base, larger codes go up.
  function automatic logic [9:0] scale_y(input logic [9:0] y_base, input logic [7:0] code);
    return y_base - {2'b00, code};
  endfunction

endpackage

// File: rtl/scope_trace_rd_if.sv
// Capture RAM read port.
//   ram_rd_en   : read enable (reader -> RAM)
//   ram_rd_addr : read address (reader -> RAM)
//   ram_rd_data : read data, valid 1 clk after ram_rd_en (RAM -> reader)
interface scope_trace_rd_if;
  import scope_trace_rd_pkg::*;

  logic              ram_rd_en;
  logic [RAM_AW-1:0] ram_rd_addr;
  logic [RAM_DW-1:0] ram_rd_data;

  modport master (output ram_rd_en, output ram_rd_addr, input ram_rd_data);
  modport slave  (input ram_rd_en, input ram_rd_addr, output ram_rd_data);

endinterface

// File: rtl/scope_trace_rd_trace_span_cmp.sv
// Vertical span test for the interpolated trace.
//   prev_y    : row of the previous column's sample
//   cur_y     : row of this column's sample
//   ypos      : row being drawn
//   first_col : column 0, span collapses to a single dot at cur_y
//   hit       : ypos lies within [min, max] of the two rows
module scope_trace_rd_trace_span_cmp (
  input  logic [9:0] prev_y,
  input  logic [9:0] cur_y,
  input  logic [9:0] ypos,
  input  logic       first_col,
  output logic       hit
);

  logic [9:0] lo;
  logic [9:0] hi;

  always_comb begin
    lo = cur_y;
    hi = cur_y;
    if (!first_col) begin
      if (prev_y < cur_y) lo = prev_y;
      else                hi = prev_y;
    end
    hit = (ypos >= lo) && (ypos <= hi);
  end

endmodule

// File: rtl/scope_trace_rd.sv
// Display-side reader of the 1024x12 capture RAM.
// Follows the VGA raster, reads one sample per active pixel and emits the
// trace/grid colour two clocks after the pixel strobe. A frame-lock
// handshake keeps the writer from restarting a capture mid-frame.
//   clk, rst_n              : 50 MHz clock, asynchronous active-low reset
//   pix_en                  : one-clk pixel strobe
//   pixel_xpos, pixel_ypos  : raster position incl. blanking
//   buf_ready               : writer pulse, a full capture is complete
//   frame_lock              : high while a frame is being drawn
//   ram                     : capture RAM read port
//   vga_wave                : 6-bit pixel colour, 0 = background
module scope_trace_rd
  import scope_trace_rd_pkg::*;
#(
  parameter int unsigned H_ACT    = H_ACT_DEF,
  parameter int unsigned V_ACT    = V_ACT_DEF,
  parameter int unsigned Y_BASE   = 367,
  parameter int unsigned H_OFFSET = 0,
  parameter int unsigned GRID_DIV = 64,
  parameter logic [5:0]  C_TRACE  = C_TRACE_DEF,
  parameter logic [5:0]  C_GRID   = C_GRID_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pix_en,
  input  logic [9:0]              pixel_xpos,
  input  logic [9:0]              pixel_ypos,
  input  logic                    buf_ready,
  output logic                    frame_lock,
  scope_trace_rd_if.master        ram,
  output logic [5:0]              vga_wave
);

  localparam logic [9:0] H_ACT_W  = 10'(H_ACT);
  localparam logic [9:0] V_ACT_W  = 10'(V_ACT);
  localparam logic [9:0] H_LAST   = 10'(H_ACT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACT - 1);
  localparam logic [9:0] Y_BASE_W = 10'(Y_BASE);
  localparam logic [9:0] H_OFF_W  = 10'(H_OFFSET);
  localparam logic [9:0] G_MASK   = 10'(GRID_DIV - 1);

  state_e     state_q, state_d;
  logic       pend_q, pend_d;
  logic       stb_q, stb_d;
  logic       act_q, act_d;
  logic       rd_q, rd_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [9:0] prev_y_q, prev_y_d;
  logic [5:0] wave_q, wave_d;

  logic       active, frame_start, frame_end, rd_en;
  logic [9:0] cur_y;
  logic       span_hit, grid_hit;
  logic       unused_sinks;

  assign active      = (pixel_xpos < H_ACT_W) && (pixel_ypos < V_ACT_W);
  assign frame_start = pix_en && (pixel_xpos == '0) && (pixel_ypos == '0);
  assign frame_end   = pix_en && (pixel_ypos == V_ACT_W);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_IDLE:   if (buf_ready && !frame_start) state_d = S_ARMED;
      S_ARMED:  if (frame_start) state_d = S_DRAW;
      S_DRAW: begin
        if (buf_ready) pend_d = 1'b1;
        if (frame_end) begin
          state_d = S_VBLANK;
          pend_d  = 1'b0;
        end
      end
      S_VBLANK: if (frame_start) state_d = S_DRAW;
      default:  state_d = S_IDLE;
    endcase
  end

  // Keyed on the next state so the frame-start pixel (0,0) is read too.
  assign rd_en           = pix_en && active && (state_d == S_DRAW);
  assign ram.ram_rd_en   = rd_en;
  assign ram.ram_rd_addr = rd_en ? (H_OFF_W + pixel_xpos) : '0;
  assign frame_lock      = (state_q == S_DRAW);
  assign vga_wave        = wave_q;

  // Stage 1: coordinates of the strobed pixel, aligned with the RAM read.
  always_comb begin
    stb_d = pix_en;
    act_d = active;
    rd_d  = rd_en;
    x_d   = pixel_xpos;
    y_d   = pixel_ypos;
  end

  // Stage 2: RAM data arrives; resolve colour for the pixel held in stage 1.
  assign cur_y = scale_y(Y_BASE_W, ram.ram_rd_data[11:4]);

  scope_trace_rd_trace_span_cmp u_span (
    .prev_y    (prev_y_q),
    .cur_y     (cur_y),
    .ypos      (y_q),
    .first_col (x_q == '0),
    .hit       (span_hit)
  );

  assign grid_hit = ((x_q & G_MASK) == '0) || ((y_q & G_MASK) == '0) ||
                    (x_q == H_LAST) || (y_q == V_LAST);

  always_comb begin
    wave_d   = wave_q;
    prev_y_d = prev_y_q;
    if (stb_q) begin
      if (!act_q)                wave_d = '0;
      else if (rd_q && span_hit) wave_d = C_TRACE;
      else if (grid_hit)         wave_d = C_GRID;
      else                       wave_d = '0;
      if (rd_q) prev_y_d = cur_y;
    end
  end

  // pend is state only; nothing in this block consumes it yet.
  assign unused_sinks = ^{pend_q, ram.ram_rd_data[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      stb_q    <= 1'b0;
      act_q    <= 1'b0;
      rd_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      prev_y_q <= '0;
      wave_q   <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      stb_q    <= stb_d;
      act_q    <= act_d;
      rd_q     <= rd_d;
      x_q      <= x_d;
      y_q      <= y_d;
      prev_y_q <= prev_y_d;
      wave_q   <= wave_d;
    end
  end

endmodule

// File: tb/tb_scope_trace_rd.sv
module tb_scope_trace_rd;

  localparam logic [5:0] TRACE = 6'b111100;
  localparam logic [5:0] GRID  = 6'b000101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic       buf_ready;
  logic [9:0] pixel_xpos;
  logic [9:0] pixel_ypos;
  logic       frame_lock, frame_lock2;
  logic [5:0] vga_wave, vga_wave2;

  int vectors = 0;
  int miscompares = 0;
  int rd_cnt = 0;

  logic       en_s, en2_s;
  logic [9:0] addr_s, addr2_s;
  logic [5:0] w_early, w_s, w2_s;

  logic [11:0] mem [1024];

  always #5 clk = ~clk;

  scope_trace_rd_if ram_if ();
  scope_trace_rd_if ram_if2 ();

  always @(posedge clk) begin
    if (ram_if.ram_rd_en) ram_if.ram_rd_data <= mem[ram_if.ram_rd_addr];
    if (ram_if.ram_rd_en) rd_cnt <= rd_cnt + 1;
  end
  assign ram_if2.ram_rd_data = 12'h800;

  scope_trace_rd u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .buf_ready  (buf_ready),
    .frame_lock (frame_lock),
    .ram        (ram_if.master),
    .vga_wave   (vga_wave)
  );

  scope_trace_rd #(.H_OFFSET(1000)) u_off (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .buf_ready  (buf_ready),
    .frame_lock (frame_lock2),
    .ram        (ram_if2.master),
    .vga_wave   (vga_wave2)
  );

  function automatic logic [5:0] grid_exp(input int unsigned x, input int unsigned y);
    if (x >= 640 || y >= 480) return 6'd0;
    if ((x % 64 == 0) || (y % 64 == 0) || x == 639 || y == 479) return GRID;
    return 6'd0;
  endfunction

  // One pixel strobe; samples read port, colour one clk later (early) and two clks later.
  task automatic pix(input int unsigned x, input int unsigned y, input logic br);
    pixel_xpos = 10'(x);
    pixel_ypos = 10'(y);
    pix_en     = 1'b1;
    buf_ready  = br;
    #1;
    en_s    = ram_if.ram_rd_en;
    addr_s  = ram_if.ram_rd_addr;
    en2_s   = ram_if2.ram_rd_en;
    addr2_s = ram_if2.ram_rd_addr;
    @(posedge clk); #1;
    pix_en    = 1'b0;
    buf_ready = 1'b0;
    w_early   = vga_wave;
    @(posedge clk); #1;
    w_s  = vga_wave;
    w2_s = vga_wave2;
  endtask

  task automatic pulse_buf_ready();
    buf_ready = 1'b1;
    @(posedge clk); #1;
    buf_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix_en = 1'b0; buf_ready = 1'b0;
    pixel_xpos = '0; pixel_ypos = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (frame_lock !== 1'b0) begin miscompares++; $display("FAIL reset_lock got %b want 0", frame_lock); end
    vectors++;
    if (ram_if.ram_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en got %b want 0", ram_if.ram_rd_en); end
    vectors++;
    if (ram_if.ram_rd_addr !== 10'd0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", ram_if.ram_rd_addr); end
    vectors++;
    if (vga_wave !== 6'd0) begin miscompares++; $display("FAIL reset_wave got %b want 0", vga_wave); end
    vectors++;
    if (u_dut.pend_q !== 1'b0) begin miscompares++; $display("FAIL reset_pend got %b want 0", u_dut.pend_q); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_grid_only();
    int unsigned rows [5] = '{0, 1, 64, 100, 479};
    int rd0 = rd_cnt;
    pix(0, 0, 1'b0);
    foreach (rows[r]) begin
      for (int unsigned x = 0; x < 640; x++) begin
        pix(x, rows[r], 1'b0);
        vectors++;
        if (w_s !== grid_exp(x, rows[r])) begin
          miscompares++;
          $display("FAIL grid x=%0d y=%0d got %b want %b", x, rows[r], w_s, grid_exp(x, rows[r]));
        end
      end
    end
    pix(700, 10, 1'b0);
    vectors++;
    if (w_s !== 6'd0) begin miscompares++; $display("FAIL grid_hblank got %b want 0", w_s); end
    pix(0, 500, 1'b0);
    vectors++;
    if (w_s !== 6'd0) begin miscompares++; $display("FAIL grid_vblank got %b want 0", w_s); end
    vectors++;
    if (rd_cnt !== rd0) begin miscompares++; $display("FAIL idle_reads got %0d want %0d", rd_cnt, rd0); end
    vectors++;
    if (frame_lock !== 1'b0) begin miscompares++; $display("FAIL idle_lock got %b want 0", frame_lock); end
  endtask

  task automatic test_const_trace();
    for (int i = 0; i < 1024; i++) mem[i] = 12'h800;
    pulse_buf_ready();
    vectors++;
    if (frame_lock !== 1'b0) begin miscompares++; $display("FAIL armed_lock got %b want 0", frame_lock); end
    pix(0, 0, 1'b0);
    vectors++;
    if (frame_lock !== 1'b1) begin miscompares++; $display("FAIL draw_lock got %b want 1", frame_lock); end
    vectors++;
    if (w_s !== GRID) begin miscompares++; $display("FAIL origin got %b want %b", w_s, GRID); end
    for (int unsigned x = 0; x < 640; x++) begin
      pix(x, 239, 1'b0);
      vectors++;
      if (en_s !== 1'b1 || addr_s !== 10'(x)) begin
        miscompares++;
        $display("FAIL rd x=%0d got en=%b addr=%0d want en=1 addr=%0d", x, en_s, addr_s, x);
      end
      vectors++;
      if (w_s !== TRACE) begin
        miscompares++;
        $display("FAIL row239 x=%0d got %b want %b", x, w_s, TRACE);
      end
      if (x == 0) begin
        vectors++;
        if (w_early !== GRID) begin miscompares++; $display("FAIL latency got %b want %b", w_early, GRID); end
      end
    end
    pix(5, 238, 1'b0);
    vectors++;
    if (w_s !== 6'd0) begin miscompares++; $display("FAIL row238 got %b want 0", w_s); end
    pix(700, 239, 1'b0);
    vectors++;
    if (en_s !== 1'b0 || w_s !== 6'd0) begin
      miscompares++; $display("FAIL hblank got en=%b wave=%b want en=0 wave=0", en_s, w_s);
    end
    pix(0, 480, 1'b0);
    vectors++;
    if (frame_lock !== 1'b0) begin miscompares++; $display("FAIL vblank_lock got %b want 0", frame_lock); end
  endtask

  task automatic test_ramp();
    int unsigned rows [5] = '{111, 112, 200, 367, 368};
    logic [5:0] exp;
    mem[0] = 12'h000;
    mem[1] = 12'hFF0;
    pix(0, 0, 1'b0);
    foreach (rows[r]) begin
      pix(0, rows[r], 1'b0);
      exp = (rows[r] == 367) ? TRACE : GRID;
      vectors++;
      if (w_s !== exp) begin
        miscompares++; $display("FAIL ramp_c0 y=%0d got %b want %b", rows[r], w_s, exp);
      end
      pix(1, rows[r], 1'b0);
      exp = (rows[r] >= 112 && rows[r] <= 367) ? TRACE : grid_exp(1, rows[r]);
      vectors++;
      if (w_s !== exp) begin
        miscompares++; $display("FAIL ramp_c1 y=%0d got %b want %b", rows[r], w_s, exp);
      end
    end
    pix(0, 480, 1'b0);
  endtask

  task automatic test_wrap();
    pix(0, 0, 1'b0);
    pix(0, 239, 1'b0);
    pix(23, 239, 1'b0);
    vectors++;
    if (addr2_s !== 10'd1023) begin miscompares++; $display("FAIL wrap23 got %0d want 1023", addr2_s); end
    pix(24, 239, 1'b0);
    vectors++;
    if (addr2_s !== 10'd0) begin miscompares++; $display("FAIL wrap24 got %0d want 0", addr2_s); end
    pix(30, 239, 1'b0);
    vectors++;
    if (en2_s !== 1'b1 || addr2_s !== 10'd6) begin
      miscompares++; $display("FAIL wrap30 got en=%b addr=%0d want en=1 addr=6", en2_s, addr2_s);
    end
    vectors++;
    if (w2_s !== TRACE || frame_lock2 !== 1'b1) begin
      miscompares++; $display("FAIL wrap_wave got wave=%b lock=%b want %b lock=1", w2_s, frame_lock2, TRACE);
    end
    pix(0, 480, 1'b0);
  endtask

  task automatic test_pend();
    pix(0, 0, 1'b0);
    vectors++;
    if (u_dut.pend_q !== 1'b0) begin miscompares++; $display("FAIL pend_start got %b want 0", u_dut.pend_q); end
    pix(10, 100, 1'b0);
    pulse_buf_ready();
    vectors++;
    if (u_dut.pend_q !== 1'b1 || frame_lock !== 1'b1) begin
      miscompares++; $display("FAIL pend_set got pend=%b lock=%b want 1 1", u_dut.pend_q, frame_lock);
    end
    pix(0, 479, 1'b0);
    vectors++;
    if (frame_lock !== 1'b1) begin miscompares++; $display("FAIL lock_479 got %b want 1", frame_lock); end
    pix(0, 480, 1'b0);
    vectors++;
    if (frame_lock !== 1'b0 || u_dut.pend_q !== 1'b0) begin
      miscompares++; $display("FAIL lock_480 got lock=%b pend=%b want 0 0", frame_lock, u_dut.pend_q);
    end
    pix(0, 0, 1'b1);
    vectors++;
    if (frame_lock !== 1'b1 || u_dut.pend_q !== 1'b0) begin
      miscompares++; $display("FAIL start_vs_ready got lock=%b pend=%b want 1 0", frame_lock, u_dut.pend_q);
    end
  endtask

  task automatic test_reset_mid_draw();
    pix(3, 239, 1'b0);
    vectors++;
    if (w_s !== TRACE) begin miscompares++; $display("FAIL pre_reset got %b want %b", w_s, TRACE); end
    pixel_xpos = 10'd4;
    pixel_ypos = 10'd239;
    pix_en     = 1'b1;
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (frame_lock !== 1'b0 || vga_wave !== 6'd0 || ram_if.ram_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got lock=%b wave=%b rd_en=%b want 0 0 0", frame_lock, vga_wave, ram_if.ram_rd_en);
    end
    pix_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pix(5, 239, 1'b0);
    vectors++;
    if (w_s !== 6'd0 || en_s !== 1'b0) begin
      miscompares++; $display("FAIL post_reset got wave=%b en=%b want 0 0", w_s, en_s);
    end
    pix(0, 0, 1'b0);
    vectors++;
    if (frame_lock !== 1'b0) begin miscompares++; $display("FAIL post_reset_lock got %b want 0", frame_lock); end
  endtask

  initial begin
    test_reset();
    test_grid_only();
    test_const_trace();
    test_ramp();
    test_wrap();
    test_pend();
    test_reset_mid_draw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
